// File: rtl/smartcargo_pkg.sv
// Shared types and constants for the elevator stop-queue insertion planner.
// Queue entry layout: {eh_origem, tipo[1:0], origem[1:0], parada[1:0]}.
package smartcargo_pkg;

  localparam int QUEUE_DEPTH = 16;
  localparam int ADDR_W      = $clog2(QUEUE_DEPTH);
  localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENTRY_W     = 7;

  localparam int EH_ORIGEM = 6;
  localparam int TIPO_HI   = 5;
  localparam int TIPO_LO   = 4;
  localparam int ORIG_HI   = 3;
  localparam int ORIG_LO   = 2;
  localparam int PARADA_HI = 1;
  localparam int PARADA_LO = 0;
  localparam int PARADA_W  = PARADA_HI - PARADA_LO + 1;

  // A request needs room for two entries, so 15+ occupied means reject.
  localparam logic [CNT_W-1:0] LIMITE_CHEIO = CNT_W'(QUEUE_DEPTH - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    VARRE_ORIG,
    GRAVA_ORIG,
    VARRE_DEST,
    GRAVA_DEST,
    FIM
  } estado_t;

  typedef struct packed {
    logic [1:0]          tipo;
    logic [PARADA_W-1:0] origem;
    logic [PARADA_W-1:0] destino;
  } pedido_t;

  function automatic logic [ENTRY_W-1:0] monta_entrada(logic eh_origem, pedido_t p);
    return {eh_origem, p.tipo, p.origem, (eh_origem ? p.origem : p.destino)};
  endfunction

endpackage

// File: rtl/planejador_insercao_if.sv
// Request, queue-RAM and status signals of the insertion planner.
interface planejador_insercao_if;
  import smartcargo_pkg::*;

  logic                iniciar;
  logic [1:0]          in_tipo;
  logic [PARADA_W-1:0] in_origem;
  logic [PARADA_W-1:0] in_destino;
  logic                consumir;
  logic [PARADA_W-1:0] ram_parada;
  logic [PARADA_W-1:0] ram_parada_ant;

  logic [ADDR_W-1:0]   addr_sec;
  logic [ADDR_W-1:0]   addr_sec_ant;
  logic                fit;
  logic                weT;
  logic                out_eh_origem;
  logic [1:0]          out_tipo;
  logic [PARADA_W-1:0] out_origem;
  logic [PARADA_W-1:0] out_destino;
  logic                ocupado;
  logic                pronto;
  logic                erro_cheio;
  logic [CNT_W-1:0]    num_entradas;

  modport master (
    output iniciar, in_tipo, in_origem, in_destino, consumir, ram_parada, ram_parada_ant,
    input  addr_sec, addr_sec_ant, fit, weT, out_eh_origem, out_tipo, out_origem,
           out_destino, ocupado, pronto, erro_cheio, num_entradas
  );

  modport slave (
    input  iniciar, in_tipo, in_origem, in_destino, consumir, ram_parada, ram_parada_ant,
    output addr_sec, addr_sec_ant, fit, weT, out_eh_origem, out_tipo, out_origem,
           out_destino, ocupado, pronto, erro_cheio, num_entradas
  );

endinterface

// File: rtl/comparador_entre.sv
// True when alvo lies strictly between two consecutive stops, in either direction.
module comparador_entre
  import smartcargo_pkg::*;
(
  input  logic [PARADA_W-1:0] ant,
  input  logic [PARADA_W-1:0] atual,
  input  logic [PARADA_W-1:0] alvo,
  output logic                entre
);

  assign entre = ((ant < alvo) && (alvo < atual)) ||
                 ((ant > alvo) && (alvo > atual));

endmodule

// File: rtl/planejador_insercao.sv
// Scans the external stop queue one index per cycle and inserts a request's
// origin then destination entry, either in a between-floors gap or at the tail.
module planejador_insercao
  import smartcargo_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear_n,
  planejador_insercao_if.slave bus
);

  estado_t             estado;
  pedido_t             req;
  logic [ADDR_W-1:0]   k, pos, pos_grav, pos_ef, k_ant;
  logic [CNT_W-1:0]    num, num_prox;
  logic [ENTRY_W-1:0]  dado_q;
  logic                fit_q, wet_q, pronto_q, erro_q;
  logic [PARADA_W-1:0] alvo;
  logic                entre, no_fim, gravando, eh_orig;

  assign eh_orig  = (estado == VARRE_ORIG);
  assign alvo     = eh_orig ? req.origem : req.destino;
  assign no_fim   = ({1'b0, k} >= num);
  assign gravando = fit_q | wet_q;
  assign k_ant    = (k == '0) ? '0 : k - 1'b1;

  // Where the origin landed; a same-cycle head removal shifts it down by one.
  assign pos_grav = fit_q ? k : num[ADDR_W-1:0];
  assign pos_ef   = (bus.consumir && pos_grav != '0) ? pos_grav - 1'b1 : pos_grav;

  comparador_entre u_cmp (
    .ant   (bus.ram_parada_ant),
    .atual (bus.ram_parada),
    .alvo  (alvo),
    .entre (entre)
  );

  always_comb begin
    num_prox = num;
    if (gravando && !bus.consumir)
      num_prox = num + 1'b1;
    else if (!gravando && bus.consumir && num != '0)
      num_prox = num - 1'b1;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      estado   <= OCIOSO;
      req      <= '0;
      k        <= '0;
      pos      <= '0;
      num      <= '0;
      dado_q   <= '0;
      fit_q    <= 1'b0;
      wet_q    <= 1'b0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      num      <= num_prox;
      dado_q   <= '0;
      fit_q    <= 1'b0;
      wet_q    <= 1'b0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.iniciar) begin
            if (num >= LIMITE_CHEIO) begin
              erro_q <= 1'b1;
            end else begin
              req    <= '{tipo: bus.in_tipo, origem: bus.in_origem, destino: bus.in_destino};
              k      <= ADDR_W'(1);
              estado <= VARRE_ORIG;
            end
          end
        end
        VARRE_ORIG, VARRE_DEST: begin
          // RAM contents shift under us on consumir, so restart this phase.
          if (bus.consumir) begin
            if (eh_orig) begin
              k <= ADDR_W'(1);
            end else begin
              k   <= (pos == '0) ? ADDR_W'(1) : pos;
              pos <= (pos == '0) ? '0 : pos - 1'b1;
            end
          end else if (no_fim || entre) begin
            fit_q  <= !no_fim;
            wet_q  <= no_fim;
            dado_q <= monta_entrada(eh_orig, req);
            estado <= eh_orig ? GRAVA_ORIG : GRAVA_DEST;
          end else begin
            k <= k + 1'b1;
          end
        end
        GRAVA_ORIG: begin
          pos    <= pos_ef;
          k      <= pos_ef + 1'b1;
          estado <= VARRE_DEST;
        end
        GRAVA_DEST: begin
          pronto_q <= 1'b1;
          estado   <= FIM;
        end
        FIM: begin
          k      <= '0;
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.addr_sec      = k;
  assign bus.addr_sec_ant  = k_ant;
  assign bus.fit           = fit_q;
  assign bus.weT           = wet_q;
  assign bus.out_eh_origem = dado_q[EH_ORIGEM];
  assign bus.out_tipo      = dado_q[TIPO_HI:TIPO_LO];
  assign bus.out_origem    = dado_q[ORIG_HI:ORIG_LO];
  assign bus.out_destino   = dado_q[PARADA_HI:PARADA_LO];
  assign bus.ocupado       = (estado != OCIOSO);
  assign bus.pronto        = pronto_q;
  assign bus.erro_cheio    = erro_q;
  assign bus.num_entradas  = num;

endmodule

// File: tb/tb_planejador_insercao.sv
// Directed bench: behavioural queue RAM around the planner, hand-computed expectations.
module tb_planejador_insercao;
  import smartcargo_pkg::*;

  logic clk = 1'b0;
  logic clear_n;
  always #5 clk = ~clk;

  planejador_insercao_if bus ();
  planejador_insercao dut (.clk(clk), .clear_n(clear_n), .bus(bus));

  // queue RAM model: insert-with-shift on fit, tail write on weT, head pop on consumir
  logic [ENTRY_W-1:0] fila [QUEUE_DEPTH];
  int                 cnt;
  logic [ENTRY_W-1:0] nova;
  assign nova = {bus.out_eh_origem, bus.out_tipo, bus.out_origem, bus.out_destino};
  assign bus.ram_parada     = fila[bus.addr_sec][1:0];
  assign bus.ram_parada_ant = fila[bus.addr_sec_ant][1:0];

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= 0;
      for (int i = 0; i < QUEUE_DEPTH; i++) fila[i] <= '0;
    end else if (bus.fit) begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (i == int'(bus.addr_sec)) fila[i] <= nova;
        else if (i > int'(bus.addr_sec)) fila[i] <= fila[(i > 0) ? i - 1 : 0];
      cnt <= cnt + 1;
    end else if (bus.weT) begin
      fila[cnt] <= nova;
      cnt <= cnt + 1;
    end else if (bus.consumir) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) fila[i] <= fila[i+1];
      cnt <= cnt - 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] paradas(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = (r << 2) | 32'(fila[i][1:0]);
    return r;
  endfunction

  logic               wr_fit [4];
  logic [ADDR_W-1:0]  wr_addr[4];
  logic [ENTRY_W-1:0] wr_dat [4];
  int                 wr_n;
  int                 lat;

  task automatic reset_dut();
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulso_consumir();
    bus.consumir = 1'b1;
    @(negedge clk);
    bus.consumir = 1'b0;
    @(negedge clk);
  endtask

  // Issues one request and logs its writes; inj_at!=0 pops the head when addr_sec hits it.
  task automatic do_req(input logic [1:0] t, input logic [1:0] o, input logic [1:0] d,
                        input int inj_at, output int l);
    int n0;
    bit inj;
    n0 = int'(bus.num_entradas);
    wr_n = 0;
    inj = 1'b0;
    l = -1;
    bus.in_tipo = t; bus.in_origem = o; bus.in_destino = d;
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    chk("ocupado", bus.ocupado, 1);
    for (int c = 0; c < 60; c++) begin
      if (bus.consumir) begin
        bus.consumir = 1'b0;
        chk("restart_k", bus.addr_sec, 1);
        chk("cons_num", bus.num_entradas, n0 - 1);
      end else if (inj_at != 0 && !inj && int'(bus.addr_sec) == inj_at) begin
        bus.consumir = 1'b1;
        inj = 1'b1;
      end
      if (bus.fit || bus.weT) begin
        if (wr_n < 4) begin
          wr_fit[wr_n]  = bus.fit;
          wr_addr[wr_n] = bus.addr_sec;
          wr_dat[wr_n]  = nova;
        end
        wr_n++;
      end
      if (bus.pronto) begin
        l = c;
        break;
      end
      @(negedge clk);
    end
    chk("pronto_seen", (l >= 0), 1);
    if (inj_at == 0) chk("latency_bound", (l <= n0 + 4), 1);
    @(negedge clk);
  endtask

  initial begin
    bit vista;
    clear_n = 1'b0;
    bus.iniciar = 1'b0; bus.consumir = 1'b0;
    bus.in_tipo = '0; bus.in_origem = '0; bus.in_destino = '0;
    repeat (2) @(negedge clk);
    chk("rst_pulses", {bus.fit, bus.weT, bus.pronto, bus.erro_cheio, bus.ocupado}, 0);
    chk("rst_num", bus.num_entradas, 0);
    chk("rst_addr", {bus.addr_sec, bus.addr_sec_ant}, 0);
    chk("rst_data", {bus.out_eh_origem, bus.out_tipo, bus.out_origem, bus.out_destino}, 0);
    clear_n = 1'b1;
    @(negedge clk);
    chk("no_wr_after_rst", {bus.fit, bus.weT}, 0);

    // empty queue: both entries appended
    do_req(2'd2, 2'd1, 2'd3, 0, lat);
    chk("t1_wr_n", wr_n, 2);
    chk("t1_kind0", wr_fit[0], 0);
    chk("t1_dat0", wr_dat[0], 7'b1_10_01_01);
    chk("t1_kind1", wr_fit[1], 0);
    chk("t1_dat1", wr_dat[1], 7'b0_10_01_11);
    chk("t1_latency", lat, 4);
    chk("t1_num", bus.num_entradas, 2);
    chk("t1_stops", paradas(2), 4'b01_11);
    chk("t1_pronto_1cyc", {bus.pronto, bus.ocupado}, 0);

    // upward gap: [0,3] + (1->2)
    reset_dut();
    do_req(2'd0, 2'd0, 2'd3, 0, lat);
    do_req(2'd0, 2'd1, 2'd2, 0, lat);
    chk("t2_fit0", {wr_fit[0], wr_addr[0]}, {1'b1, 4'd1});
    chk("t2_dat0", wr_dat[0], 7'b1_00_01_01);
    chk("t2_fit1", {wr_fit[1], wr_addr[1]}, {1'b1, 4'd2});
    chk("t2_dat1", wr_dat[1], 7'b0_00_01_10);
    chk("t2_stops", paradas(4), 8'b00_01_10_11);
    chk("t2_num", bus.num_entradas, 4);

    // downward gap: [3,0] + (2->1)
    reset_dut();
    do_req(2'd0, 2'd3, 2'd0, 0, lat);
    do_req(2'd3, 2'd2, 2'd1, 0, lat);
    chk("t3_fit0", {wr_fit[0], wr_addr[0]}, {1'b1, 4'd1});
    chk("t3_dat0", wr_dat[0], 7'b1_11_10_10);
    chk("t3_fit1", {wr_fit[1], wr_addr[1]}, {1'b1, 4'd2});
    chk("t3_dat1", wr_dat[1], 7'b0_11_10_01);
    chk("t3_stops", paradas(4), 8'b11_10_01_00);

    // fill to the limits: 14 accepted, 15 rejected
    reset_dut();
    for (int r = 0; r < 7; r++) do_req(2'd0, 2'd0, 2'd3, 0, lat);
    chk("t4_num14", bus.num_entradas, 14);
    do_req(2'd0, 2'd0, 2'd3, 0, lat);
    chk("t4_wr_at14", wr_n, 2);
    chk("t4_num16", bus.num_entradas, 16);
    pulso_consumir();
    chk("t4_num15", bus.num_entradas, 15);
    bus.in_tipo = 2'd1; bus.in_origem = 2'd1; bus.in_destino = 2'd2;
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    chk("t4_erro", {bus.erro_cheio, bus.fit, bus.weT, bus.ocupado}, 4'b1000);
    @(negedge clk);
    chk("t4_erro_1cyc", {bus.erro_cheio, bus.fit, bus.weT, bus.ocupado}, 0);
    chk("t4_num_kept", bus.num_entradas, 15);

    // head removed mid origin scan with 5 entries
    reset_dut();
    for (int r = 0; r < 3; r++) do_req(2'd0, 2'd0, 2'd3, 0, lat);
    chk("t5_stops6", paradas(6), 12'b00_11_00_11_00_11);
    pulso_consumir();
    chk("t5_num5", bus.num_entradas, 5);
    do_req(2'd1, 2'd3, 2'd1, 3, lat);
    chk("t5_wr_n", wr_n, 2);
    chk("t5_dat0", {wr_fit[0], wr_addr[0], wr_dat[0]}, {1'b0, 4'd4, 7'b1_01_11_11});
    chk("t5_dat1", {wr_fit[1], wr_dat[1]}, {1'b0, 7'b0_01_11_01});
    chk("t5_num", bus.num_entradas, 6);
    chk("t5_stops", paradas(6), 12'b00_11_00_11_11_01);

    // clear during destination scan, then a normal request
    reset_dut();
    do_req(2'd0, 2'd0, 2'd3, 0, lat);
    bus.in_tipo = 2'd0; bus.in_origem = 2'd1; bus.in_destino = 2'd2;
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    vista = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.fit) begin
        vista = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_orig_fit", vista, 1);
    @(negedge clk);
    chk("t6_busy", bus.ocupado, 1);
    clear_n = 1'b0;
    #1;
    chk("t6_clr_pulses", {bus.fit, bus.weT, bus.pronto, bus.erro_cheio, bus.ocupado}, 0);
    chk("t6_clr_num", bus.num_entradas, 0);
    chk("t6_clr_addr", bus.addr_sec, 0);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    do_req(2'd1, 2'd2, 2'd0, 0, lat);
    chk("t6_wr_n", wr_n, 2);
    chk("t6_dat0", wr_dat[0], 7'b1_01_10_10);
    chk("t6_dat1", wr_dat[1], 7'b0_01_10_00);
    chk("t6_num", bus.num_entradas, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/planejador_insercao.md
PLANEJADOR_INSERCAO -- requirements
Module: planejador_insercao

Interface
REQ-001 SHALL have ports: clk in 1 (system clock, rising edge); clear_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have ports: iniciar in 1 (one-cycle new-request pulse); in_tipo in 2; in_origem in 2; in_destino in 2 (request floors 0-3).
REQ-003 SHALL have port consumir in 1: pulse, same cycle as the queue RAM shift, meaning the head entry was removed.
REQ-004 SHALL have ports: ram_parada in 2 (bits[1:0] of queue entry at addr_sec, combinational); ram_parada_ant in 2 (same for addr_sec_ant).
REQ-005 SHALL have outputs: addr_sec out 4; addr_sec_ant out 4; fit out 1; weT out 1; out_eh_origem out 1; out_tipo out 2; out_origem out 2; out_destino out 2.
REQ-006 SHALL have outputs: ocupado out 1 (request in progress); pronto out 1 (one-cycle completion pulse); erro_cheio out 1 (one-cycle reject pulse); num_entradas out 5 (occupied queue entries, 0-16).

Function
REQ-007 Stop floor of every queue entry SHALL be bits[1:0]; origin entry written as {1, tipo, origem, origem}; destination entry as {0, tipo, origem, destino}.
REQ-008 States SHALL be OCIOSO, VARRE_ORIG, GRAVA_ORIG, VARRE_DEST, GRAVA_DEST, FIM; ocupado=1 in every state except OCIOSO.
REQ-009 OCIOSO + iniciar with num_entradas<=14: latch fields, k:=1, go VARRE_ORIG; iniciar with num_entradas>=15: erro_cheio=1 next cycle, stay OCIOSO, no write.
REQ-010 iniciar while ocupado=1 SHALL be ignored.
REQ-011 VARRE_x: drive addr_sec=k, addr_sec_ant=k-1; target T = in_origem (VARRE_ORIG) or in_destino (VARRE_DEST).
REQ-012 If k>=num_entradas, go GRAVA_x in append mode; else if ram_parada_ant<T<ram_parada or ram_parada_ant>T>ram_parada (strict), go GRAVA_x in fit mode at k; else k:=k+1. One index per cycle.
REQ-013 Index 0 (head in service) SHALL never be a fit position; an empty queue (num_entradas=0) appends at 0.
REQ-014 GRAVA_x SHALL assert exactly one of fit (addr_sec=k) or weT for one cycle, with the REQ-007 data on out_* that same cycle.
REQ-015 Each write SHALL increment num_entradas; each consumir SHALL decrement it (saturating at 0); both in one cycle SHALL leave it unchanged.
REQ-016 After GRAVA_ORIG, let p = position written (k, or old num_entradas if appended); then k:=p+1, go VARRE_DEST. The destination is therefore always after its origin.
REQ-017 GRAVA_DEST -> FIM; FIM asserts pronto for one cycle, then goes OCIOSO.
REQ-018 consumir during VARRE_x SHALL restart that phase at k:=1 (VARRE_ORIG) or k:=max(p,1) (VARRE_DEST, with p decremented).
REQ-019 consumir in a GRAVA_x cycle SHALL not cancel the write.
REQ-020 Worst-case latency iniciar->pronto SHALL be num_entradas+4 cycles absent consumir.
REQ-021 fit, weT, pronto, erro_cheio SHALL be registered outputs, never asserted together.

Reset
REQ-022 clear_n=0 SHALL immediately force OCIOSO, num_entradas=0, k=0, and all outputs 0, including mid-operation.
REQ-023 No write SHALL be issued in the first clk edge after clear_n deasserts.

Structure
REQ-024 State encoding, entry-format bit positions (EH_ORIGEM=6, PARADA=1:0), and QUEUE_DEPTH=16 SHALL live in the shared package smartcargo_pkg.
REQ-025 The between-floors comparison SHALL be the sub-module comparador_entre (inputs ant, atual, alvo; output entre).
REQ-026 The occupancy counter SHALL be in the same module; no internal copy of the queue SHALL be kept.

Verification
REQ-027 Empty queue, request origem=1 destino=3 -> weT at 0 then weT at 1 (data 7'b1_xx_01_01, 7'b0_xx_01_11), pronto, num_entradas=2.
REQ-028 Queue stops [0,3], request origem=1 destino=2 -> fit at 1 (origin), fit at 2 (destination); final stops [0,1,2,3].
REQ-029 Queue stops [3,0], request origem=2 destino=1 -> fit at 1, fit at 2; final stops [3,2,1,0].
REQ-030 num_entradas=15, iniciar -> erro_cheio one cycle, no fit/weT, num_entradas stays 15.
REQ-031 consumir pulse mid-VARRE_ORIG with 5 entries -> num_entradas=4, scan restarts at k=1, correct final positions.
REQ-032 clear_n low during VARRE_DEST -> outputs 0, num_entradas=0 immediately; next iniciar completes normally.
